// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan display.
// All segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'b0111111;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;

  localparam seg7_t SEG_0 = 7'b1000000;
  localparam seg7_t SEG_1 = 7'b1111001;
  localparam seg7_t SEG_2 = 7'b0100100;
  localparam seg7_t SEG_3 = 7'b0110000;
  localparam seg7_t SEG_4 = 7'b0011001;
  localparam seg7_t SEG_5 = 7'b0010010;
  localparam seg7_t SEG_6 = 7'b0000010;
  localparam seg7_t SEG_7 = 7'b1111000;
  localparam seg7_t SEG_8 = 7'b0000000;
  localparam seg7_t SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Non-BCD codes (A-F) render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit BCD latch multiplexed onto a common-anode seven-segment display,
// with refresh divider, leading-zero blanking and display enable.
module bcd_seg_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            sel_q;
  logic [3:0]      tens_q, ones_q;
  logic [3:0]      an_q, an_d;
  seg7_t           seg_q, seg_d;
  logic [3:0]      digit;
  seg7_t           dec;

  assign digit = sel_q ? tens_q : ones_q;

  bcd_to_seg7 u_dec (
    .digit (digit),
    .seg   (dec)
  );

  // Blanking only applies to a valid zero; an invalid tens digit still shows a dash.
  always_comb begin
    an_d  = sel_q ? AN_TENS : AN_ONES;
    seg_d = dec;
    if (!en || (BLANK_LZ && sel_q && (tens_q == 4'd0))) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= 1'b0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
    end else begin
      if (cnt_q == CntLast) begin
        cnt_q <= '0;
        sel_q <= ~sel_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (load) begin
        tens_q <= tens;
        ones_q <= ones;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized and directed check of bcd_seg_scan against a cycle-count reference model,
// with one instance per leading-zero blanking setting.
module tb_bcd_seg_scan;

  localparam int unsigned Div = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic       en = 1'b1;

  logic [6:0] seg_b, seg_n;
  logic       dp_b, dp_n;
  logic [3:0] an_b, an_n;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bcd_seg_scan #(.REFRESH_DIV(Div), .BLANK_LZ(1'b1)) u_dut_blank (
    .clk(clk), .rst_n(rst_n), .load(load), .tens(tens), .ones(ones), .en(en),
    .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  bcd_seg_scan #(.REFRESH_DIV(Div), .BLANK_LZ(1'b0)) u_dut_noblank (
    .clk(clk), .rst_n(rst_n), .load(load), .tens(tens), .ones(ones), .en(en),
    .seg(seg_n), .dp(dp_n), .an(an_n)
  );

  // Reference model: edges since reset release, latched digits, expected pins.
  int         m_edges = 0;
  logic [3:0] m_tens = 4'd0;
  logic [3:0] m_ones = 4'd0;
  logic [6:0] exp_seg_b = 7'h7F, exp_seg_n = 7'h7F;
  logic [3:0] exp_an_b = 4'hF, exp_an_n = 4'hF;

  logic [6:0] patterns [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    if (d > 4'd9) return 7'b0111111;
    return patterns[d];
  endfunction

  task automatic model_edge();
    bit tens_slot;
    if (!rst_n) begin
      m_edges = 0;
      m_tens = 4'd0;
      m_ones = 4'd0;
      exp_an_b = 4'hF; exp_seg_b = 7'h7F;
      exp_an_n = 4'hF; exp_seg_n = 7'h7F;
    end else begin
      tens_slot = ((m_edges / Div) % 2) == 1;
      if (!en) begin
        exp_an_b = 4'hF; exp_seg_b = 7'h7F;
        exp_an_n = 4'hF; exp_seg_n = 7'h7F;
      end else if (tens_slot) begin
        exp_an_n = 4'b1101; exp_seg_n = glyph(m_tens);
        if (m_tens == 4'd0) begin
          exp_an_b = 4'hF; exp_seg_b = 7'h7F;
        end else begin
          exp_an_b = 4'b1101; exp_seg_b = glyph(m_tens);
        end
      end else begin
        exp_an_b = 4'b1110; exp_seg_b = glyph(m_ones);
        exp_an_n = 4'b1110; exp_seg_n = glyph(m_ones);
      end
      if (load) begin
        m_tens = tens;
        m_ones = ones;
      end
      m_edges++;
    end
  endtask

  // One clock: model the edge, then compare the pins shortly after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("an_blz1", 32'(an_b), 32'(exp_an_b));
    check("seg_blz1", 32'(seg_b), 32'(exp_seg_b));
    check("an_blz0", 32'(an_n), 32'(exp_an_n));
    check("seg_blz0", 32'(seg_n), 32'(exp_seg_n));
    check("dp", 32'({dp_b, dp_n}), 32'(2'b11));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_digits(input logic [3:0] t, input logic [3:0] o);
    tens = t; ones = o; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // Scenario 1: reset, release, default zeros.
    rst_n = 1'b0;
    steps(3);
    check("rst_an", 32'(an_b), 32'(4'hF));
    check("rst_seg", 32'(seg_b), 32'(7'h7F));
    rst_n = 1'b1;
    step();
    check("s1_ones_an", 32'(an_b), 32'(4'b1110));
    check("s1_ones_seg", 32'(seg_b), 32'(7'b1000000));
    steps(3);
    step();
    check("s1_tens_blank", 32'(an_b), 32'(4'hF));
    steps(3);

    // Scenarios 2-4: 42, 07, invalid B/C.
    load_digits(4'd4, 4'd2);
    steps(16);
    load_digits(4'd0, 4'd7);
    steps(16);
    load_digits(4'hB, 4'hC);
    steps(16);

    // Scenario 5: drop en at cycle 2 of a tens slot for 5 cycles.
    load_digits(4'd3, 4'd8);
    while ((m_edges % (2 * Div)) != Div + 1) step();
    en = 1'b0;
    steps(5);
    en = 1'b1;
    steps(10);

    // Scenario 6: reset and load on the same edge mid tens slot.
    while ((m_edges % (2 * Div)) != Div + 2) step();
    rst_n = 1'b0; tens = 4'd5; ones = 4'd9; load = 1'b1;
    step();
    check("s6_rst_an", 32'(an_b), 32'(4'hF));
    rst_n = 1'b1; load = 1'b0;
    load_digits(4'd5, 4'd9);
    step();
    check("s6_cap_an", 32'(an_b), 32'(4'b1110));
    check("s6_cap_seg", 32'(seg_b), 32'(7'b0010000));
    steps(8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 9) == 0);
      tens  = 4'($urandom_range(0, 15));
      ones  = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Downstream consumer of the 6-bit binary-to-BCD converter. Latches a two-digit BCD value (tens, ones) and time-multiplexes it onto a common-anode four-digit seven-segment display, two digits used. Provides a refresh divider, leading-zero blanking, invalid-digit indication and a display enable. Outputs drive board pins directly.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
BLANK_LZ, 1, 1 = blank the tens digit when it is 0; 0 = show "0".

Ports:
clk    input   1  system clock; all logic on rising edge.
rst_n  input   1  synchronous, active-low reset.
load   input   1  capture strobe for tens/ones; sampled every clk edge.
tens   input   4  BCD tens digit from the converter.
ones   input   4  BCD ones digit from the converter.
en     input   1  display enable; 0 blanks the display.
seg    output  7  segments {g,f,e,d,c,b,a}, active-low.
dp     output  1  decimal point, active-low; constant 1 (off).
an     output  4  anode selects, active-low; an[3:2] always 1.

Behaviour:
- Reset (rst_n=0 at an edge): tens_q=0, ones_q=0, refresh count=0, sel=0. Registered outputs an=4'b1111, seg=7'b1111111, dp=1. Reset wins over load on the same edge.
- Capture: load=1 at edge N writes tens/ones into tens_q/ones_q. No handshake back; load may be held high, which recaptures every cycle.
- Refresh counter: counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and sel toggles on the same edge. The counter runs regardless of en and load. Width = $clog2(REFRESH_DIV).
- Slot mapping: sel=0 -> ones_q on an=4'b1110. sel=1 -> tens_q on an=4'b1101.
- Outputs are registered, so each slot lasts exactly REFRESH_DIV cycles on the pins.
  - seg/an reflect sel and the holding registers one edge later.
  - A value captured at edge N appears at edge N+1 if its digit is in the current slot.
- Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Invalid digit (4'hA-4'hF): dash, seg=7'b0111111. This applies in either slot. Blanking does not apply to invalid digits.
- Leading-zero blank: when BLANK_LZ=1, sel=1 and tens_q==0, then an=4'b1111 and seg=7'b1111111.
- en=0: an=4'b1111 and seg=7'b1111111 from the next edge. Counter and sel keep running. On en returning to 1, the next edge shows the current slot; there is no slot restart.
- Reset mid-slot: counter and sel restart. The first post-reset slot is ones and lasts a full REFRESH_DIV cycles starting at release.
- No glitch: an and seg change on the same edge, from a single output register.

Decomposition:
- Package seg7_pkg holds:
  - seg7_t, a 7-bit typedef.
  - Constants SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, AN_OFF=4'hF, AN_ONES=4'b1110, AN_TENS=4'b1101.
  - The digit pattern constants.
- Sub-module bcd_to_seg7: combinational 4-bit in to seg7_t out, including the dash for invalid digits. Instantiated once and fed by a mux on sel.
- Top-level bcd_seg_scan holds the counter, sel, holding registers, blank logic and output register.

Test Plan:
All scenarios use REFRESH_DIV=4.
1. rst_n=0 for 3 cycles, then released with en=1 and no load -> an=1111, seg=1111111, dp=1 during reset. After release: ones slot an=1110 seg=1000000 for 4 cycles. Then the tens slot is blanked (an=1111).
2. load=1 for 1 cycle with tens=4, ones=2, en=1 -> repeating pattern: 4 cycles an=1110 seg=0100100, then 4 cycles an=1101 seg=0011001. dp=1 throughout.
3. tens=0, ones=7 -> ones slot seg=1111000. With BLANK_LZ=1 the tens slot is an=1111, seg=1111111. Rerun with BLANK_LZ=0: tens slot an=1101, seg=1000000.
4. tens=4'hB, ones=4'hC -> both slots seg=0111111 on their anodes, with BLANK_LZ=1.
5. en dropped at cycle 2 of a tens slot for 5 cycles -> an=1111, seg=7F from the next edge. On re-enable, the display resumes in the slot dictated by the free-running counter (ones slot, 3rd cycle), checked against a reference counter model.
6. rst_n=0 and load=1 (tens=5, ones=9) on the same edge, mid tens slot -> after the edge tens_q=0, ones_q=0, sel=0, count=0, an=1111. load asserted again after release -> an=1110, seg=0010000 one edge after capture.
